// File: rtl/wiener_filter_apply.sv
// Wiener gain computation and per-block pixel filtering: out = mean + gain*(x - mean).
// Gain is Q1.8 from a 9-cycle restoring divider; pixel path is a 2-stage pipeline.
module wiener_filter_apply #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_of_frame,
  input  logic [2*DATA_WIDTH-1:0] noise_variance,
  input  logic [2*DATA_WIDTH-1:0] block_variance,
  input  logic [2*DATA_WIDTH-1:0] mean_in,
  input  logic                    variance_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    filter_ready,
  output logic [8:0]              gain_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  output logic                    overrun
);

  localparam int SW = 2*DATA_WIDTH;
  localparam int CW = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam int PW = DATA_WIDTH + 12;
  localparam logic [CW-1:0] LAST = CW'(TOTAL_SAMPLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FILTER} state_t;
  state_t r_state, w_state_nxt;

  logic                  r_pending, r_overrun;
  logic [SW-1:0]         r_p_noise, r_p_var;
  logic [DATA_WIDTH-1:0] r_p_mean;
  logic [SW:0]           r_rem;
  logic [SW-1:0]         r_dvar;
  logic                  r_zero;
  logic [DATA_WIDTH-1:0] r_dmean, r_mean, r_m1, r_dout;
  logic [3:0]            r_dcnt;
  logic [7:0]            r_q;
  logic [8:0]            r_gain;
  logic [CW-1:0]         r_pix;
  logic                  r_v1, r_vout;
  logic signed [PW-1:0]  r_prod;

  logic                  w_clr, w_accept, w_last, w_div_done, w_load;
  logic [DATA_WIDTH-1:0] w_mean8, w_src_mean;
  logic [SW-1:0]         w_src_noise, w_src_var, w_src_diff;
  logic                  w_src_zero, w_bit;
  logic [SW:0]           w_trial, w_rem_nxt;
  logic signed [DATA_WIDTH+1:0] w_diff;
  logic signed [PW-1:0]  w_prod;
  logic signed [PW:0]    w_rnd, w_scaled, w_sum;
  logic [DATA_WIDTH-1:0] w_clamp;

  assign w_clr      = rst | start_of_frame;
  assign w_accept   = data_valid && (r_state == S_FILTER);
  assign w_last     = w_accept && (r_pix == LAST);
  assign w_div_done = (r_state == S_DIVIDE) && (r_dcnt == 4'd8);
  assign w_load     = ((r_state == S_IDLE) || w_last) && (variance_ready || r_pending);

  assign w_mean8 = (|mean_in[SW-1:DATA_WIDTH]) ? '1 : mean_in[DATA_WIDTH-1:0];

  // Fresh stats arriving with the load win over the buffered ones (they would overwrite it anyway)
  assign w_src_noise = variance_ready ? noise_variance : r_p_noise;
  assign w_src_var   = variance_ready ? block_variance : r_p_var;
  assign w_src_mean  = variance_ready ? w_mean8        : r_p_mean;
  assign w_src_zero  = (w_src_var == '0) || (w_src_var <= w_src_noise);
  assign w_src_diff  = w_src_zero ? '0 : (w_src_var - w_src_noise);

  // Quotient bit 8 compares the unshifted remainder; bits 7..0 shift it left first
  assign w_trial   = (r_dcnt == 4'd0) ? r_rem : {r_rem[SW-1:0], 1'b0};
  assign w_bit     = (w_trial >= {1'b0, r_dvar});
  assign w_rem_nxt = w_bit ? (w_trial - {1'b0, r_dvar}) : w_trial;

  always_ff @(posedge clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (variance_ready || r_pending) w_state_nxt = S_DIVIDE;
      S_DIVIDE: if (w_div_done) w_state_nxt = S_FILTER;
      S_FILTER: if (w_last) w_state_nxt = (variance_ready || r_pending) ? S_DIVIDE : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_p_noise <= '0;
      r_p_var   <= '0;
      r_p_mean  <= '0;
    end else begin
      if (w_load) begin
        r_pending <= 1'b0;
      end else if (variance_ready) begin
        r_pending <= 1'b1;
        r_p_noise <= noise_variance;
        r_p_var   <= block_variance;
        r_p_mean  <= w_mean8;
      end
      if ((variance_ready && r_pending) || (data_valid && (r_state != S_FILTER)))
        r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_rem   <= '0;
      r_dvar  <= '0;
      r_zero  <= 1'b0;
      r_dmean <= '0;
      r_dcnt  <= '0;
      r_q     <= '0;
      r_gain  <= '0;
      r_mean  <= '0;
    end else if (w_load) begin
      r_rem   <= {1'b0, w_src_diff};
      r_dvar  <= w_src_var;
      r_zero  <= w_src_zero;
      r_dmean <= w_src_mean;
      r_dcnt  <= '0;
      r_q     <= '0;
    end else if (r_state == S_DIVIDE) begin
      r_rem  <= w_rem_nxt;
      r_q    <= {r_q[6:0], w_bit};
      r_dcnt <= r_dcnt + 4'd1;
      if (w_div_done) begin
        r_gain <= r_zero ? 9'd0 : {r_q, w_bit};
        r_mean <= r_dmean;
      end
    end
  end

  assign w_diff   = $signed({2'b00, data_in}) - $signed({2'b00, r_mean});
  assign w_prod   = PW'(w_diff) * PW'($signed({1'b0, r_gain}));
  assign w_rnd    = $signed({r_prod[PW-1], r_prod}) + $signed((PW+1)'(128));
  assign w_scaled = w_rnd >>> 8;
  assign w_sum    = w_scaled + $signed({{(PW+1-DATA_WIDTH){1'b0}}, r_m1});
  assign w_clamp  = w_sum[PW] ? '0 : ((|w_sum[PW-1:DATA_WIDTH]) ? '1 : w_sum[DATA_WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_pix  <= '0;
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_m1   <= '0;
      r_vout <= 1'b0;
      r_dout <= '0;
    end else begin
      if (r_state != S_FILTER) r_pix <= '0;
      else if (w_accept)       r_pix <= w_last ? '0 : r_pix + CW'(1);
      r_v1   <= w_accept;
      r_prod <= w_prod;
      r_m1   <= r_mean;
      r_vout <= r_v1;
      if (r_v1) r_dout <= w_clamp;
    end
  end

  assign filter_ready   = (r_state == S_FILTER);
  assign gain_out       = r_gain;
  assign data_out       = r_dout;
  assign data_out_valid = r_vout;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_wiener_filter_apply.sv
// Self-checking bench for wiener_filter_apply: table of block cases plus
// hand-written pending/overrun/reset sequences; pixel outputs via a scoreboard queue.
module tb_wiener_filter_apply;

  logic        clk = 1'b0;
  logic        rst, start_of_frame, variance_ready, data_valid;
  logic [15:0] noise_variance, block_variance, mean_in;
  logic [7:0]  data_in;
  logic        filter_ready, data_out_valid, overrun;
  logic [8:0]  gain_out;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  wiener_filter_apply #(.DATA_WIDTH(8), .TOTAL_SAMPLES(8)) dut (
    .clk(clk), .rst(rst), .start_of_frame(start_of_frame),
    .noise_variance(noise_variance), .block_variance(block_variance), .mean_in(mean_in),
    .variance_ready(variance_ready), .data_in(data_in), .data_valid(data_valid),
    .filter_ready(filter_ready), .gain_out(gain_out), .data_out(data_out),
    .data_out_valid(data_out_valid), .overrun(overrun)
  );

  typedef struct {
    logic [15:0] noise;
    logic [15:0] bvar;
    logic [15:0] mean;
    int          gain;
    logic [7:0]  px [8];
  } vec_t;

  typedef struct { int val; int cyc; } exp_t;

  vec_t vec [7];
  exp_t q [$];
  int checks = 0, failures = 0;
  int cyc = 0;
  int cur_gain = 0, cur_mean = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mean8(input logic [15:0] m);
    return (m > 16'd255) ? 255 : int'(m);
  endfunction

  function automatic int model_pix(input int x, input int m, input int g);
    int s, y;
    s = ((x - m) * g + 128) >>> 8;
    y = m + s;
    if (y < 0)   y = 0;
    if (y > 255) y = 255;
    return y;
  endfunction

  always @(negedge clk) begin
    if (data_out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout_value", int'(data_out), e.val);
        check("dout_latency", cyc, e.cyc);
      end
    end
  end

  task automatic set_stats(input int i);
    noise_variance = vec[i].noise;
    block_variance = vec[i].bvar;
    mean_in        = vec[i].mean;
  endtask

  // vr in cycle T from IDLE; filter_ready must be low at T+9 and high at T+10
  task automatic start_block(input int i);
    set_stats(i);
    variance_ready = 1'b1;
    tick();
    variance_ready = 1'b0;
    repeat (8) tick();
    check("fr_before_T10", int'(filter_ready), 0);
    tick();
    check("fr_at_T10", int'(filter_ready), 1);
    check("gain", int'(gain_out), vec[i].gain);
    cur_gain = vec[i].gain;
    cur_mean = mean8(vec[i].mean);
  endtask

  // Drives 8 pixels of case i; optionally pulses variance_ready (stats sa/sb) with pixel pa/pb
  task automatic filter_pixels(input int i, input bit gap,
                               input int pa, input int sa, input int pb, input int sb);
    for (int p = 0; p < 8; p++) begin
      if (p == pa) begin set_stats(sa); variance_ready = 1'b1; end
      if (p == pb) begin set_stats(sb); variance_ready = 1'b1; end
      data_valid = 1'b1;
      data_in    = vec[i].px[p];
      q.push_back('{model_pix(int'(vec[i].px[p]), cur_mean, cur_gain), cyc + 2});
      tick();
      variance_ready = 1'b0;
      data_valid     = 1'b0;
      if (gap && (p % 2 == 1) && (p != 7)) tick();
    end
  endtask

  // Called at L+1 when a pending block follows; DIVIDE occupies L+1..L+9
  task automatic pending_divide(input int i);
    check("fr_drop_pending", int'(filter_ready), 0);
    repeat (8) tick();
    check("fr_before_L10", int'(filter_ready), 0);
    tick();
    check("fr_at_L10", int'(filter_ready), 1);
    check("gain_pending", int'(gain_out), vec[i].gain);
    cur_gain = vec[i].gain;
    cur_mean = mean8(vec[i].mean);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{16'd0,    16'd100,   16'd50,  256, '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70}};
    vec[1] = '{16'd100,  16'd200,   16'd100, 128, '{8'd200, 8'd0, 8'd100, 8'd255, 8'd50, 8'd150, 8'd1, 8'd99}};
    vec[2] = '{16'd80,   16'd80,    16'd77,  0,   '{8'd0, 8'd255, 8'd77, 8'd10, 8'd200, 8'd128, 8'd3, 8'd250}};
    vec[3] = '{16'd5,    16'd0,     16'd30,  0,   '{8'd255, 8'd0, 8'd30, 8'd31, 8'd29, 8'd100, 8'd7, 8'd200}};
    vec[4] = '{16'd30,   16'd100,   16'd300, 179, '{8'd0, 8'd255, 8'd128, 8'd1, 8'd254, 8'd64, 8'd190, 8'd10}};
    vec[5] = '{16'd1,    16'd3,     16'd128, 170, '{8'd255, 8'd0, 8'd128, 8'd129, 8'd127, 8'd200, 8'd20, 8'd64}};
    vec[6] = '{16'd1000, 16'd60000, 16'd200, 251, '{8'd255, 8'd0, 8'd200, 8'd100, 8'd250, 8'd180, 8'd240, 8'd210}};

    rst = 1'b1; start_of_frame = 1'b0; variance_ready = 1'b0; data_valid = 1'b0;
    noise_variance = '0; block_variance = '0; mean_in = '0; data_in = '0;
    repeat (3) tick();
    check("rst_fr", int'(filter_ready), 0);
    check("rst_gain", int'(gain_out), 0);
    check("rst_dov", int'(data_out_valid), 0);
    check("rst_dout", int'(data_out), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      start_block(i);
      filter_pixels(i, bit'(i % 2), -1, 0, -1, 0);
      check("fr_drop", int'(filter_ready), 0);
      drain();
    end

    // Pending block, then an overrun that replaces the pending stats, then vr with the last pixel
    start_block(0);
    filter_pixels(0, 1'b0, 3, 1, -1, 0);
    pending_divide(1);
    check("no_overrun", int'(overrun), 0);
    filter_pixels(1, 1'b1, 2, 2, 5, 4);
    check("overrun_set", int'(overrun), 1);
    pending_divide(4);
    filter_pixels(4, 1'b0, 7, 5, -1, 0);
    pending_divide(5);
    filter_pixels(5, 1'b0, -1, 0, -1, 0);
    check("fr_drop_final", int'(filter_ready), 0);
    drain();

    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    check("sof_overrun", int'(overrun), 0);
    check("sof_gain", int'(gain_out), 0);
    check("sof_fr", int'(filter_ready), 0);

    data_valid = 1'b1; data_in = 8'd99;
    tick();
    data_valid = 1'b0;
    check("idle_px_overrun", int'(overrun), 1);
    check("idle_px_dov1", int'(data_out_valid), 0);
    tick();
    check("idle_px_dov2", int'(data_out_valid), 0);
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    check("sof2_overrun", int'(overrun), 0);
    check("sof2_fr", int'(filter_ready), 0);

    // Reset during the 4th DIVIDE cycle after a block left nonzero gain/data
    start_block(6);
    filter_pixels(6, 1'b0, -1, 0, -1, 0);
    drain();
    set_stats(1);
    variance_ready = 1'b1;
    tick();
    variance_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_fr", int'(filter_ready), 0);
    check("abort_gain", int'(gain_out), 0);
    check("abort_dov", int'(data_out_valid), 0);
    check("abort_dout", int'(data_out), 0);
    check("abort_overrun", int'(overrun), 0);
    tick();
    start_block(1);
    filter_pixels(1, 1'b0, -1, 0, -1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wiener_filter_apply.md
# wiener_filter_apply

Downstream consumer of the block-statistics stage in the Wiener denoising pipeline. Once per block it takes the block mean and variance, computes a fixed-point Wiener gain with an iterative divider, and then filters that block's delayed pixel stream. Each pixel is filtered as `out = mean + gain·(x − mean)`, where `gain = max(var − noise_var, 0) / var`. Output pixels are written to the frame-output path.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width; statistics are 2*DATA_WIDTH wide
- TOTAL_SAMPLES, 8, pixels per block (power of 2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start_of_frame  in  1  synchronous frame restart; same effect as rst on FSM, counters, pending and overrun; does not change noise_variance usage
- noise_variance  in  2*DATA_WIDTH  frame noise variance; sampled together with block stats
- block_variance  in  2*DATA_WIDTH  block variance, valid with variance_ready
- mean_in  in  2*DATA_WIDTH  block mean, valid with variance_ready
- variance_ready  in  1  one-cycle pulse; stats valid
- data_in  in  DATA_WIDTH  delayed pixel of the current block
- data_valid  in  1  data_in valid this cycle
- filter_ready  out  1  high while in FILTER (gain valid, pixels accepted)
- gain_out  out  9  current gain, Q1.8 (256 = 1.0)
- data_out  out  DATA_WIDTH  filtered pixel
- data_out_valid  out  1  data_out valid
- overrun  out  1  sticky error flag

## Operation
- Reset values: all outputs 0; state IDLE; pending flag, pixel counter and pipeline valids cleared.
- Stats capture:
  - variance_ready always latches {noise_variance, block_variance, mean8} into a stats register.
  - mean8 = mean_in saturated to 2^DATA_WIDTH−1.
  - In IDLE, the captured stats feed the divider directly.
  - In DIVIDE or FILTER, the captured stats go to a pending buffer and the pending flag is set.
  - variance_ready while pending is already set: new values overwrite the buffer and overrun is set.
- FSM states:
  - IDLE → DIVIDE on variance_ready, or if pending is set (pending is then consumed and cleared).
  - DIVIDE lasts exactly 9 cycles, then → FILTER. gain_out and the active mean update on exiting DIVIDE.
  - FILTER accepts pixels while data_valid is high; the counter increments per accepted pixel.
  - On the TOTAL_SAMPLES-th accepted pixel: → DIVIDE if pending is set (consuming it), else → IDLE.
- Gain:
  - gain = floor(((var − noise) << 8) / var), range 0..256.
  - Forced to 0 when var == 0 or var ≤ noise.
  - The forced-zero case still takes the full 9 DIVIDE cycles.
  - Divider implementation is free; the result must be exact.
- Datapath (signed):
  - diff = x − mean8, DATA_WIDTH+2 bits.
  - prod = diff·gain.
  - scaled = (prod + 128) >>> 8 (arithmetic shift, floor).
  - y = mean8 + scaled, clamped to [0, 2^DATA_WIDTH−1].
- data_valid outside FILTER: pixel is dropped, no output is produced, and overrun is set.
- overrun: sticky; cleared only by rst or start_of_frame.
- rst or start_of_frame mid-DIVIDE or mid-FILTER: abort immediately to IDLE and flush the pipeline. Outputs are 0 in the next cycle.

## Timing
- variance_ready in cycle T while in IDLE: DIVIDE occupies T+1..T+9; filter_ready and the new gain_out are valid from T+10.
- Pixel latency is 2 cycles. data_valid with data_in in cycle P gives data_out_valid and data_out in P+2. Registers: stage 1 = diff·gain, stage 2 = add/round/clamp.
- Throughput is 1 pixel/cycle in FILTER; gaps in data_valid are allowed.
- Last pixel of a block in cycle L:
  - filter_ready drops in L+1.
  - If pending is set, DIVIDE occupies L+1..L+9.
  - Outputs for in-flight pixels still emerge in L+1 and L+2.
- variance_ready in the same cycle as the last pixel: treated as arriving during FILTER (goes to pending); the next DIVIDE starts at L+1.
- variance_ready together with rst or start_of_frame: reset wins and the stats are discarded.

## Test plan
- noise=0, var=100, mean=50, pixels 0,10,…,70 → gain_out=256; data_out equals data_in, 2-cycle latency; filter_ready rises 10 cycles after variance_ready.
- noise=100, var=200, mean=100, x=200 then x=0 → gain=128; outputs 150 then 50.
- var=80, noise=80, and var=0 cases → gain=0; every output equals mean8; DIVIDE still 9 cycles.
- Back-to-back blocks: second variance_ready mid-FILTER → pending set; DIVIDE starts the cycle after the 8th pixel; no overrun. A third variance_ready before that → overrun=1, and the third stats are used.
- data_valid in IDLE → no data_out_valid, overrun=1; start_of_frame → overrun=0, state IDLE.
- rst asserted in the 4th DIVIDE cycle → next cycle all outputs 0, filter_ready=0; a fresh variance_ready then runs a full 9-cycle DIVIDE.
